// File: rtl/ringbuf_mux_pkg.sv
// Shared definitions for the multi-channel ring buffer: sample width, round-robin grant
// helper and the fill-level width macro used when RINGBUF_MUX_LEVEL_EN is defined.
`ifndef RINGBUF_MUX_PKG_SV
`define RINGBUF_MUX_PKG_SV

// Fill level spans 0..LEN inclusive, hence one bit more than the pointer width.
`define RINGBUF_MUX_FILL_W(len_log2) ((len_log2) + 1)

package ringbuf_mux_pkg;

  localparam int unsigned SampleW = 24;

  // Arbiter helper works on a fixed maximum channel count; callers zero-pad.
  localparam int unsigned MaxCh  = 16;
  localparam int unsigned MaxChW = 4;

  typedef struct packed {
    logic              valid;
    logic [MaxChW-1:0] idx;
  } grant_t;

  // First requester at or after ptr, scanning upward modulo num_ch.
  function automatic grant_t rr_grant(input logic [MaxCh-1:0]  req,
                                      input logic [MaxChW-1:0] ptr,
                                      input int unsigned       num_ch);
    grant_t      g;
    int unsigned c;
    g = '0;
    for (int unsigned i = 0; i < MaxCh; i++) begin
      c = (32'(ptr) + i) % num_ch;
      if (i < num_ch && !g.valid && req[c[MaxChW-1:0]]) begin
        g.valid = 1'b1;
        g.idx   = c[MaxChW-1:0];
      end
    end
    return g;
  endfunction

endpackage

`endif

// File: rtl/ringbuf_mux_if.sv
// Bus bundle between the input receivers / resampler_core and ringbuf_mux.
// fill_o exists only when RINGBUF_MUX_LEVEL_EN is defined.
interface ringbuf_mux_if
  import ringbuf_mux_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned NUM_CH_LOG2 = 1,
  parameter int unsigned LEN_LOG2    = 6
);

  logic [SampleW*NUM_CH-1:0] data_i;
  logic [NUM_CH-1:0]         we_i;
  logic [NUM_CH_LOG2-1:0]    rd_ch_i;
  logic [LEN_LOG2-1:0]       offset_i;
  logic [NUM_CH-1:0]         pop_i;
  logic                      flags_clr_i;
  logic [SampleW-1:0]        data_o;
  logic [NUM_CH-1:0]         ovf_o;
  logic [NUM_CH-1:0]         unf_o;
`ifdef RINGBUF_MUX_LEVEL_EN
  logic [`RINGBUF_MUX_FILL_W(LEN_LOG2)*NUM_CH-1:0] fill_o;
`endif

  modport master (
    output data_i, we_i, rd_ch_i, offset_i, pop_i, flags_clr_i,
    input  data_o, ovf_o, unf_o
`ifdef RINGBUF_MUX_LEVEL_EN
    , fill_o
`endif
  );

  modport slave (
    input  data_i, we_i, rd_ch_i, offset_i, pop_i, flags_clr_i,
    output data_o, ovf_o, unf_o
`ifdef RINGBUF_MUX_LEVEL_EN
    , fill_o
`endif
  );

endinterface

// File: rtl/ringbuf_mux_ram.sv
// Simple dual-port RAM: synchronous write, registered read (read-before-write on collision).
// Only the read register is reset; array contents survive reset.
module ringbuf_mux_ram #(
  parameter int unsigned Depth = 128,
  parameter int unsigned AddrW = 7,
  parameter int unsigned Width = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; sees the pre-write contents of a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ringbuf_mux.sv
// Multi-channel ring buffer controller: NUM_CH FIFOs of LEN samples in one shared RAM.
// Per-channel pending registers absorb input writes and drain round-robin into the RAM write
// port; the read port is dedicated to offset reads from resampler_core.
// Optional feature macro: RINGBUF_MUX_LEVEL_EN adds the registered fill_o level output.
module ringbuf_mux
  import ringbuf_mux_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned NUM_CH_LOG2 = 1,
  parameter int unsigned LEN         = 64,
  parameter int unsigned LEN_LOG2    = 6
) (
  input logic          clk,
  input logic          rst,
  ringbuf_mux_if.slave bus
);

  localparam int unsigned CntW  = `RINGBUF_MUX_FILL_W(LEN_LOG2);
  localparam int unsigned AddrW = NUM_CH_LOG2 + LEN_LOG2;

  logic [SampleW-1:0]     pend_q [NUM_CH];
  logic [SampleW-1:0]     pend_d [NUM_CH];
  logic [NUM_CH-1:0]      pend_v_q, pend_v_d;
  logic [NUM_CH_LOG2-1:0] rr_q, rr_d;
  logic [LEN_LOG2-1:0]    rptr_q [NUM_CH];
  logic [LEN_LOG2-1:0]    rptr_d [NUM_CH];
  logic [LEN_LOG2-1:0]    wptr_q [NUM_CH];
  logic [LEN_LOG2-1:0]    wptr_d [NUM_CH];
  logic [CntW-1:0]        cnt_q [NUM_CH];
  logic [CntW-1:0]        cnt_d [NUM_CH];
  logic [NUM_CH-1:0]      ovf_q, ovf_d, unf_q, unf_d;

  grant_t                 gnt;
  logic [MaxCh-1:0]       req_ext;
  logic [NUM_CH_LOG2-1:0] gnt_ch;
  logic [NUM_CH-1:0]      drain, commit, pop_ok, full, blocked;
  logic                   unused_gnt;

  logic                   ram_we;
  logic [AddrW-1:0]       ram_waddr, ram_raddr;
  logic [SampleW-1:0]     ram_wdata, rd_data;
  logic [LEN_LOG2-1:0]    rd_off;

  // Round-robin pick of one pending entry to drain; pointer moves past the winner.
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_CH-1:0]  = pend_v_q;
    gnt                  = rr_grant(req_ext, MaxChW'(rr_q), NUM_CH);
    gnt_ch               = gnt.idx[NUM_CH_LOG2-1:0];
    drain                = '0;
    rr_d                 = rr_q;
    if (gnt.valid) begin
      drain[gnt_ch] = 1'b1;
      rr_d          = (gnt_ch == NUM_CH_LOG2'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
    end
  end

  assign unused_gnt = ^gnt.idx;

  // Per-channel pending capture, commit/pop bookkeeping and sticky flags.
  always_comb begin
    ovf_d    = ovf_q & ~{NUM_CH{bus.flags_clr_i}};
    unf_d    = unf_q & ~{NUM_CH{bus.flags_clr_i}};
    pend_v_d = pend_v_q;
    pop_ok   = '0;
    full     = '0;
    commit   = '0;
    blocked  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pend_d[k]  = pend_q[k];
      rptr_d[k]  = rptr_q[k];
      wptr_d[k]  = wptr_q[k];
      pop_ok[k]  = bus.pop_i[k] && (cnt_q[k] != '0);
      full[k]    = (cnt_q[k] == CntW'(LEN));
      // A pop in the same cycle frees the slot, so a commit into a full buffer succeeds.
      commit[k]  = drain[k] && (!full[k] || pop_ok[k]);
      blocked[k] = pend_v_q[k] && !drain[k];

      if (bus.we_i[k] && !blocked[k]) begin
        pend_d[k]   = bus.data_i[k*SampleW +: SampleW];
        pend_v_d[k] = 1'b1;
      end else if (drain[k]) begin
        pend_v_d[k] = 1'b0;
      end

      if (commit[k]) begin
        wptr_d[k] = wptr_q[k] + 1'b1;
      end
      if (pop_ok[k]) begin
        rptr_d[k] = rptr_q[k] + 1'b1;
      end
      cnt_d[k] = cnt_q[k] + CntW'(commit[k]) - CntW'(pop_ok[k]);

      if ((bus.we_i[k] && blocked[k]) || (drain[k] && !commit[k])) begin
        ovf_d[k] = 1'b1;
      end
      if (bus.pop_i[k] && !pop_ok[k]) begin
        unf_d[k] = 1'b1;
      end
    end
  end

  // RAM port addressing.
  always_comb begin
    ram_we    = |commit;
    ram_waddr = {gnt_ch, wptr_q[gnt_ch]};
    ram_wdata = pend_q[gnt_ch];
    rd_off    = rptr_q[bus.rd_ch_i] + bus.offset_i;
    ram_raddr = {bus.rd_ch_i, rd_off};
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q <= '0;
      rr_q     <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        pend_q[k] <= '0;
        rptr_q[k] <= '0;
        wptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      pend_v_q <= pend_v_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      for (int k = 0; k < NUM_CH; k++) begin
        pend_q[k] <= pend_d[k];
        rptr_q[k] <= rptr_d[k];
        wptr_q[k] <= wptr_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  ringbuf_mux_ram #(
    .Depth(NUM_CH * LEN),
    .AddrW(AddrW),
    .Width(SampleW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(rd_data)
  );

  assign bus.data_o = rd_data;
  assign bus.ovf_o  = ovf_q;
  assign bus.unf_o  = unf_q;

`ifdef RINGBUF_MUX_LEVEL_EN
  logic [CntW*NUM_CH-1:0] fill_q;

  // Fill level, one cycle behind the internal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        fill_q[k*CntW +: CntW] <= cnt_q[k];
      end
    end
  end

  assign bus.fill_o = fill_q;
`endif

endmodule

// File: tb/tb_ringbuf_mux.sv
// Directed self-checking bench for ringbuf_mux (2 channels x 64 samples).
// Fill-level checks run only when RINGBUF_MUX_LEVEL_EN is defined.
module tb_ringbuf_mux;

  localparam int unsigned NumCh     = 2;
  localparam int unsigned NumChLog2 = 1;
  localparam int unsigned Len       = 64;
  localparam int unsigned LenLog2   = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  ringbuf_mux_if #(
    .NUM_CH     (NumCh),
    .NUM_CH_LOG2(NumChLog2),
    .LEN_LOG2   (LenLog2)
  ) bus ();

  ringbuf_mux #(
    .NUM_CH     (NumCh),
    .NUM_CH_LOG2(NumChLog2),
    .LEN        (Len),
    .LEN_LOG2   (LenLog2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i        = '0;
    bus.pop_i       = '0;
    bus.flags_clr_i = 1'b0;
    bus.rd_ch_i     = '0;
    bus.offset_i    = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Present one sample to channel ch for one cycle (captured at the next edge).
  task automatic put(input int ch, input logic [23:0] v);
    bus.data_i[ch*24 +: 24] = v;
    bus.we_i                = '0;
    bus.we_i[ch]            = 1'b1;
    tick();
    bus.we_i                = '0;
  endtask

  task automatic read_chk(input string tag, input int ch, input int off,
                          input logic [23:0] exp);
    bus.rd_ch_i  = ch[NumChLog2-1:0];
    bus.offset_i = off[LenLog2-1:0];
    tick();
    check_eq(tag, 32'(bus.data_o), 32'(exp));
  endtask

`ifdef RINGBUF_MUX_LEVEL_EN
  int m_cnt, m_pend, m_fill;
`endif

  initial begin
    bus.data_i = '0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_data", 32'(bus.data_o), 32'h0);
    check_eq("rst_ovf", 32'(bus.ovf_o), 32'h0);
    check_eq("rst_unf", 32'(bus.unf_o), 32'h0);
    rst = 1'b0;

    // 1: five ch0 samples, then offset reads with one-cycle latency.
    for (int i = 1; i <= 5; i++) begin
      bus.data_i[23:0] = 24'(i);
      bus.we_i         = 2'b01;
      tick();
    end
    bus.we_i = '0;
    tick();
    for (int j = 0; j < 5; j++) begin
      read_chk($sformatf("t1_off%0d", j), 0, j, 24'(j + 1));
    end
    check_eq("t1_ovf", 32'(bus.ovf_o), 32'h0);

    // 2: simultaneous writes drain ch0 then ch1; RAM keeps old data across reset.
    do_reset();
    bus.data_i = {24'hB, 24'hA};
    bus.we_i   = 2'b11;
    tick();
    bus.we_i     = '0;
    bus.rd_ch_i  = 1'b0;
    bus.offset_i = '0;
    tick();
    check_eq("t2_rbw_old", 32'(bus.data_o), 32'h1);
    tick();
    check_eq("t2_ch0_A", 32'(bus.data_o), 32'hA);
    read_chk("t2_ch1_B", 1, 0, 24'hB);
    put(0, 24'hC);
    tick();
    // Pointer now sits on ch1, so the next pair drains ch1 first.
    bus.data_i = {24'hF, 24'hE};
    bus.we_i   = 2'b11;
    tick();
    bus.we_i     = '0;
    bus.rd_ch_i  = 1'b1;
    bus.offset_i = 6'd1;
    tick();
    tick();
    check_eq("t2_ch1_first", 32'(bus.data_o), 32'hF);
    read_chk("t2_ch0_E", 0, 2, 24'hE);
    check_eq("t2_ovf", 32'(bus.ovf_o), 32'h0);

    // 3: overflow on ch1; clear; set beats clear in the same cycle.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      bus.data_i[47:24] = 24'(32'h100 + i);
      bus.we_i          = 2'b10;
      tick();
    end
    bus.data_i[47:24] = 24'h999;
    tick();
    check_eq("t3_full_no_ovf", 32'(bus.ovf_o), 32'h0);
    bus.we_i = '0;
    tick();
    check_eq("t3_ovf", 32'(bus.ovf_o), 32'h2);
    read_chk("t3_off0", 1, 0, 24'h100);
    read_chk("t3_off63", 1, 63, 24'h13F);
    put(1, 24'h777);
    bus.flags_clr_i = 1'b1;
    tick();
    bus.flags_clr_i = 1'b0;
    check_eq("t3_set_wins", 32'(bus.ovf_o), 32'h2);
    bus.flags_clr_i = 1'b1;
    tick();
    bus.flags_clr_i = 1'b0;
    check_eq("t3_clr", 32'(bus.ovf_o), 32'h0);

    // 4: underflow, then pointer advance by a real pop.
    do_reset();
    bus.pop_i = 2'b01;
    tick();
    bus.pop_i = '0;
    check_eq("t4_unf", 32'(bus.unf_o), 32'h1);
    bus.flags_clr_i = 1'b1;
    tick();
    bus.flags_clr_i = 1'b0;
    check_eq("t4_unf_clr", 32'(bus.unf_o), 32'h0);
    put(0, 24'h7);
    tick();
    read_chk("t4_rptr_held", 0, 0, 24'h7);
    bus.pop_i = 2'b01;
    tick();
    bus.pop_i = '0;
    check_eq("t4_pop_ok", 32'(bus.unf_o), 32'h0);
    put(0, 24'h55);
    tick();
    read_chk("t4_after_pop", 0, 0, 24'h55);

    // 5: commit into a full buffer with a same-cycle pop.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      bus.data_i[23:0] = 24'(32'h200 + i);
      bus.we_i         = 2'b01;
      tick();
    end
    bus.data_i[23:0] = 24'h3AA;
    tick();
    bus.we_i  = '0;
    bus.pop_i = 2'b01;
    tick();
    bus.pop_i = '0;
    tick();
    check_eq("t5_no_ovf", 32'(bus.ovf_o), 32'h0);
    read_chk("t5_off63", 0, 63, 24'h3AA);
    read_chk("t5_off0", 0, 0, 24'h201);
    put(0, 24'h3BB);
    tick();
    check_eq("t5_still_full", 32'(bus.ovf_o), 32'h1);

`ifdef RINGBUF_MUX_LEVEL_EN
    // 6: fill level tracks a model through wrap, then clears on reset.
    do_reset();
    m_cnt  = 0;
    m_pend = 0;
    m_fill = 0;
    for (int c = 0; c < 80; c++) begin
      bus.data_i[23:0] = 24'(c);
      bus.we_i         = (c < 70) ? 2'b01 : 2'b00;
      bus.pop_i        = (c % 3 == 2) ? 2'b01 : 2'b00;
      tick();
      m_fill = m_cnt;
      m_cnt  = m_cnt + m_pend - ((c % 3 == 2 && m_cnt > 0) ? 1 : 0);
      m_pend = (c < 70) ? 1 : 0;
      check_eq($sformatf("t6_fill_c%0d", c), 32'(bus.fill_o[6:0]), 32'(m_fill));
    end
    check_eq("t6_fill_ch1", 32'(bus.fill_o[13:7]), 32'h0);
    bus.we_i  = '0;
    bus.pop_i = '0;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    check_eq("t6_rst_fill", 32'(bus.fill_o), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
